// File: rtl/clk_div_monitor.sv
// Measures period and high time of an asynchronous divided clock in system-clock cycles,
// flags out-of-tolerance measurements, counts errors and detects a stalled input.
module clk_div_monitor #(
    parameter int CNT_W = 8,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             en,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_high,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             match,
    output logic             timeout,
    output logic [7:0]       err_cnt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [7:0]       ERR_MAX  = 8'hFF;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cap_q, high_cap_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             rise, fall;
    logic [CNT_W:0]   high_ext, exp_ext, high_diff;
    logic             match_w;

    // clk_in is asynchronous: two flops for metastability, a third to find edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= clk_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~hist_q;
    assign fall = ~sync2_q & hist_q;

    // Deviation is taken one bit wider so a small high time never wraps to a huge one.
    always_comb begin
        high_ext  = {1'b0, high_cap_q};
        exp_ext   = {1'b0, exp_high};
        high_diff = (high_ext >= exp_ext) ? (high_ext - exp_ext) : (exp_ext - high_ext);
        match_w   = (cnt_q == exp_period) && (high_diff <= TOL_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            high_cap_q    <= '0;
            meas_valid_q  <= 1'b0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            match_q       <= 1'b0;
            timeout_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_cap_q    <= high_cap_d;
            meas_valid_q  <= meas_valid_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            match_q       <= match_d;
            timeout_q     <= timeout_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_cap_d    = high_cap_q;
        meas_valid_d  = 1'b0;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        match_d       = match_q;
        timeout_d     = timeout_q;
        err_cnt_d     = err_cnt_q;

        // Disable wins over everything, including a rise seen in the same cycle.
        if (!en) begin
            state_d   = IDLE;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = CNT_ZERO;
                end
                ARM: begin
                    if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                    end else if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                        state_d   = ARM;
                    end else if (rise) begin
                        meas_valid_d  = 1'b1;
                        meas_period_d = cnt_q;
                        meas_high_d   = high_cap_q;
                        match_d       = match_w;
                        cnt_d         = CNT_ONE;
                        if (!match_w && (err_cnt_q != ERR_MAX)) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            high_cap_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign meas_valid  = meas_valid_q;
    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign match       = match_q;
    assign timeout     = timeout_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random divided clocks,
// checked every cycle against an edge-timestamp model of the monitor.
module tb_clk_div_monitor;
  localparam int CNT_W = 8;
  localparam int TOL   = 1;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int W     = 2 * CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_in = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] exp_period = '0;
  logic [CNT_W-1:0] exp_high = '0;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             match;
  logic             timeout;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;

  clk_div_monitor #(.CNT_W(CNT_W), .TOL(TOL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .en         (en),
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .meas_valid (meas_valid),
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .match      (match),
    .timeout    (timeout),
    .err_cnt    (err_cnt),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing is kept as edge timestamps: a count is "edges since the reference edge".
  logic [W-1:0] exp_q[$];
  bit samp[3];
  int m_edge = 0;
  int m_mode = 0;       // 0 idle, 1 armed, 2 measuring
  int m_ref = 0;        // edge at which arming (re)started
  int m_last_rise = 0;  // edge at which the current period started
  int m_high_seen = 0;
  bit m_mv = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_match = 0;
  bit m_to = 0;
  int m_err = 0;

  initial begin
    bit rise, fall;
    int per, dev;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        samp = '{0, 0, 0};
        m_mode = 0; m_mv = 0; m_period = 0; m_high = 0; m_match = 0;
        m_to = 0; m_err = 0; m_high_seen = 0;
        exp_q.delete();
      end else begin
        m_edge++;
        // clk_in seen two and three edges ago is what the edge detector compares
        rise = samp[1] && !samp[2];
        fall = !samp[1] && samp[2];
        samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = clk_in;
        m_mv = 0;
        if (!en) begin
          m_mode = 0;
          m_to = 0;
        end else if (m_mode == 0) begin
          m_mode = 1;
          m_ref = m_edge;
        end else if (m_mode == 1) begin
          if (m_edge - m_ref - 1 == MAXC) begin
            m_to = 1;
            m_ref = m_edge;
          end else if (rise) begin
            m_mode = 2;
            m_last_rise = m_edge;
          end
        end else begin
          if (m_edge - m_last_rise == MAXC) begin
            m_to = 1;
            m_mode = 1;
            m_ref = m_edge;
          end else if (rise) begin
            per = m_edge - m_last_rise;
            dev = m_high_seen - int'(exp_high);
            if (dev < 0) dev = -dev;
            m_period = per;
            m_high = m_high_seen;
            m_match = (per == int'(exp_period)) && (dev <= TOL);
            if (!m_match && m_err < 255) m_err++;
            m_mv = 1;
            exp_q.push_back({CNT_W'(per), CNT_W'(m_high_seen), m_match});
            m_last_rise = m_edge;
          end else if (fall) begin
            m_high_seen = m_edge - m_last_rise;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int mv_cyc[$];
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      check("meas_valid", meas_valid, m_mv);
      check("meas_period", meas_period, m_period);
      check("meas_high", meas_high, m_high);
      check("match", match, m_match);
      check("timeout", timeout, m_to);
      check("err_cnt", err_cnt, m_err);
      check("state", dbg_state, m_mode);
      if (meas_valid) begin
        mv_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_period", meas_period, e[W-1:CNT_W+1]);
          check("sb_high", meas_high, e[CNT_W:1]);
          check("sb_match", match, e[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  int rise_cyc[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int n, input int h);
    clk_in = 1'b1;
    rise_cyc.push_back(cyc);
    tick(h);
    clk_in = 1'b0;
    tick(n - h);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, n, h;
    logic [CNT_W-1:0] held_period;
    @(negedge clk);
    tick(3);
    check("reset_meas_period", meas_period, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    tick(2);

    // divide-by-8, 50% duty
    exp_period = 8; exp_high = 4; en = 1'b1;
    tick(3);
    rise_cyc.delete(); mv_cyc.delete();
    repeat (7) drive_period(8, 4);
    tick(4);
    check("div8_count", mv_cyc.size(), 6);
    if (mv_cyc.size() >= 2 && rise_cyc.size() >= 2) begin
      check("div8_latency", mv_cyc[0] - rise_cyc[1], 3);
      check("div8_spacing", mv_cyc[1] - mv_cyc[0], 8);
    end else begin
      check("div8_enough_pulses", mv_cyc.size(), 2);
    end
    check("div8_period", meas_period, 8);
    check("div8_high", meas_high, 4);
    check("div8_match", match, 1);
    check("model_div8_period", m_period, 8);

    // en low holds the results
    en = 1'b0;
    tick(3);
    check("hold_period", meas_period, 8);
    check("hold_match", match, 1);

    // divide-by-7 with sampled high of 3 or 4
    exp_period = 7; exp_high = 4; en = 1'b1;
    tick(3);
    repeat (8) begin
      h = $urandom_range(3, 4);
      drive_period(7, h);
    end
    tick(4);
    check("div7_err", err_cnt, 0);
    check("div7_period", meas_period, 7);
    check("div7_match", match, 1);

    // divide-by-6 against expected 7
    en = 1'b0; tick(2);
    exp_period = 7; exp_high = 3; en = 1'b1;
    tick(3);
    repeat (6) drive_period(6, 3);
    tick(4);
    check("div6_err5", err_cnt, 5);
    check("div6_match", match, 0);
    repeat (300) drive_period(6, 3);
    tick(4);
    check("div6_err_sat", err_cnt, 255);

    // stalled input -> timeout, then recovery with timeout sticky
    en = 1'b0; tick(2);
    exp_period = 4; exp_high = 2; clk_in = 1'b0; en = 1'b1;
    n0 = mv_cyc.size();
    tick(250);
    check("stall_no_timeout_yet", timeout, 0);
    tick(50);
    check("stall_timeout", timeout, 1);
    check("stall_no_valid", mv_cyc.size(), n0);
    repeat (10) drive_period(4, 2);
    tick(4);
    check("resume_count", mv_cyc.size() - n0, 9);
    check("resume_timeout_sticky", timeout, 1);
    check("resume_period", meas_period, 4);
    check("resume_match", match, 1);
    en = 1'b0;
    tick(1);
    check("en_clears_timeout", timeout, 0);
    en = 1'b1;

    // en dropped in the cycle a rise is detected
    exp_period = 8; exp_high = 4;
    tick(2);
    repeat (3) drive_period(8, 4);
    n0 = mv_cyc.size();
    held_period = meas_period;
    clk_in = 1'b1;
    tick(2);
    en = 1'b0;
    tick(2);
    clk_in = 1'b0;
    tick(6);
    check("drop_no_valid", mv_cyc.size(), n0);
    check("drop_hold_period", meas_period, held_period);
    check("drop_hold_literal", meas_period, 8);

    // reset mid-period clears outputs without a clock edge
    exp_period = 7; en = 1'b1;
    tick(2);
    repeat (3) drive_period(6, 3);
    clk_in = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", meas_valid, 0);
    check("async_rst_period", meas_period, 0);
    check("async_rst_high", meas_high, 0);
    check("async_rst_match", match, 0);
    check("async_rst_timeout", timeout, 0);
    check("async_rst_err", err_cnt, 0);
    @(negedge clk);
    clk_in = 1'b0;
    rst_n = 1'b1;
    tick(3);

    // random divided clocks, expectations and enable pulses
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        exp_period = CNT_W'($urandom_range(2, 16));
        exp_high = CNT_W'($urandom_range(0, 16));
      end
      n = $urandom_range(2, 16);
      h = $urandom_range(1, n - 1);
      drive_period(n, h);
      if ($urandom_range(0, 19) == 0) begin
        en = 1'b0;
        tick($urandom_range(1, 3));
        en = 1'b1;
      end
    end
    tick(10);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the period and high-time counters.
REQ-002 The block SHALL have parameter TOL, default 1, setting the allowed high-time deviation in clk cycles.
REQ-003 Port clk  input  1  the single system clock; all flops SHALL be rising-edge clk except as stated.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port clk_in  input  1  divided clock under test; asynchronous to clk.
REQ-006 Port en  input  1  monitor enable, level-sensitive.
REQ-007 Port exp_period  input  CNT_W  expected period in clk cycles.
REQ-008 Port exp_high  input  CNT_W  expected high time in clk cycles.
REQ-009 Port meas_valid  output  1  one-cycle pulse marking a new measurement.
REQ-010 Port meas_period  output  CNT_W  last measured period.
REQ-011 Port meas_high  output  CNT_W  last measured high time.
REQ-012 Port match  output  1  last measurement within spec; updated with meas_valid.
REQ-013 Port timeout  output  1  sticky; no rising edge of clk_in within 2^CNT_W-1 cycles.
REQ-014 Port err_cnt  output  8  saturating count of mismatching measurements.

Function
REQ-015 clk_in SHALL pass through a 2-flop synchronizer plus one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-016 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-017 IDLE: when en=1, go to ARM next cycle and clear cnt to 0.
REQ-018 ARM: cnt increments each cycle; on rise, load cnt<=1 and go to MEASURE.
REQ-019 MEASURE: cnt increments each cycle; on fall, capture high_cap<=cnt.
REQ-020 MEASURE on rise: meas_period<=cnt, meas_high<=high_cap, meas_valid=1 for exactly one cycle, cnt<=1, stay in MEASURE (back-to-back).
REQ-021 Result: a divide-by-N input with sampled high time H SHALL report meas_period=N, meas_high=H, with measurement latency of 3 clk cycles after the clk_in edge (synchronizer + edge detect + register).
REQ-022 match SHALL be registered in the same cycle as meas_period, and SHALL be 1 iff period==exp_period and |high_cap-exp_high|<=TOL, computed at CNT_W+1 bits with no wrap.
REQ-023 On meas_valid with match=0, err_cnt SHALL increment and saturate at 255.
REQ-024 If cnt reaches 2^CNT_W-1 in ARM or MEASURE: set timeout=1, go to ARM, clear cnt, no meas_valid; cnt SHALL never wrap.
REQ-025 timeout SHALL be cleared only by en=0 or reset, and SHALL remain 1 through later valid measurements.
REQ-026 en=0 in any state: go to IDLE next cycle, suppress any same-cycle meas_valid (en wins over rise), clear timeout.
REQ-027 en=0 SHALL hold meas_period, meas_high, match and err_cnt at their last values.
REQ-028 Periods below 2 clk cycles (divide-by-1) are unmeasurable; such inputs SHALL produce no meas_valid, and the behaviour is timeout or arbitrary, with no other guarantee.
REQ-029 The first rise after ARM SHALL only start timing, never emit meas_valid.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=IDLE; synchronizer and history flops=0; cnt, high_cap=0; meas_valid=0; meas_period=0; meas_high=0; match=0; timeout=0; err_cnt=0.
REQ-031 Reset asserted mid-measurement SHALL discard the partial measurement; release SHALL resume from IDLE.

Verification
REQ-032 Divide-by-8, 50% duty, exp_period=8, exp_high=4, en=1 -> first meas_valid on 2nd rising edge of clk_in +3 cycles; meas_period=8, meas_high=4, match=1, pulses every 8 cycles.
REQ-033 Divide-by-7 generated with pos/neg-edge OR (sampled high 3 or 4), exp_period=7, exp_high=4, TOL=1 -> meas_period=7, match=1, err_cnt stays 0.
REQ-034 Divide-by-6 with exp_period=7 for 5 periods -> match=0 each time, err_cnt=5; 300 mismatches -> err_cnt=255.
REQ-035 clk_in held low for 300 cycles with CNT_W=8 -> timeout=1 at cycle 255 after arm, no meas_valid; restart divide-by-4 -> measurements resume with timeout still 1; pulse en low -> timeout=0.
REQ-036 en dropped in the cycle a rise is detected -> no meas_valid, outputs hold; rst_n pulsed mid-period -> all outputs 0 immediately, without waiting for a clk edge.
